simd_accum_dsp: RTL

- Parametrised SIMD frame accumulator built on a single DSP48E2 in ALU-only (no multiplier) mode.
- Successor to the fixed TWO24 adder wrapper. Adds:
  - selectable SIMD lane split (2x24 or 4x12);
  - per-frame accumulation control through a dynamic OPMODE;
  - a sample counter, frame termination and an output valid.
- Sits in front-end datapaths, e.g. the boxcar/decimation sums of packed sample lanes ahead of trigger and threshold logic.

---
 rtl/simd_accum_dsp.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/simd_accum_dsp.sv
`default_nettype none
// ============================================================================
//  Module   : simd_accum_dsp
//  Purpose  : SIMD frame accumulator on one DSP48E2-style ALU slice
//             (no multiplier). The 48-bit input is split into 2x24 or 4x12
//             unsigned lanes. Each lane sums one frame of samples modulo
//             2^LW, and the per-lane sums are emitted with a one-cycle valid
//             strobe and the frame length.
//  Options  : define SIMD_ACCUM_OVF_EN to enable sticky per-lane carry-out
//             (wrap) flags on ovf_o. Without it, ovf_o is tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module simd_accum_dsp #(
  parameter string SIMD  = "TWO24",
  parameter int    NSAMP = 16,
  localparam int   CNTW  = $clog2(NSAMP + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [47:0]     dat_i,
  input  logic            valid_i,
  input  logic            last_i,
  output logic [47:0]     dat_o,
  output logic            valid_o,
  output logic [CNTW-1:0] count_o,
  output logic [3:0]      ovf_o
);

  localparam int NLANE = (SIMD == "FOUR12") ? 4 : 2;
  localparam int LW    = 48 / NLANE;

  generate
    if ((SIMD != "TWO24") && (SIMD != "FOUR12")) begin : g_bad_simd
      $error("simd_accum_dsp: SIMD must be TWO24 or FOUR12");
    end
    if ((NSAMP < 1) || (NSAMP > 4096)) begin : g_bad_nsamp
      $error("simd_accum_dsp: NSAMP must be in 1..4096");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Frame control (fabric)
  // --------------------------------------------------------------------------
  logic            r_first;     // next accepted sample opens a new frame
  logic [CNTW-1:0] r_cnt;       // samples accepted so far in the open frame
  logic [CNTW-1:0] w_num;       // ordinal of the sample currently offered
  logic            w_eof;       // offered sample closes the frame
  logic            r_eof_d1;    // end-of-frame pipe, aligned with the A/B stage
  logic [CNTW-1:0] r_cnt_d1;    // frame length pipe, aligned with the A/B stage

  // Sample ordinal and frame-end decode for the sample on the inputs
  always_comb begin
    w_num = r_first ? CNTW'(1) : (r_cnt + CNTW'(1));
    w_eof = valid_i && (last_i || (w_num == CNTW'(NSAMP)));
  end

  // Frame state, count pipe and output strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_first  <= 1'b1;
      r_cnt    <= '0;
      r_eof_d1 <= 1'b0;
      r_cnt_d1 <= '0;
      valid_o  <= 1'b0;
      count_o  <= '0;
    end else begin
      if (valid_i) begin
        if (w_eof) begin
          r_first <= 1'b1;
          r_cnt   <= '0;
        end else begin
          r_first <= 1'b0;
          r_cnt   <= w_num;
        end
      end
      r_eof_d1 <= w_eof;
      if (w_eof) begin
        r_cnt_d1 <= w_num;
      end
      valid_o <= r_eof_d1;
      if (r_eof_d1) begin
        count_o <= r_cnt_d1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // DSP slice: AREG/BREG/OPMODEREG stage, then the SIMD ALU into PREG.
  // X = A:B, Y = 0, Z = P (accumulate) or 0 (first sample of a frame).
  // --------------------------------------------------------------------------
  logic [47:0] r_ab;       // A:B input registers (CE = valid_i)
  logic        r_zacc;     // registered OPMODE Z-select: 1 = P, 0 = zero
  logic        r_ce_p;     // CEP: valid_i delayed to line up with A/B
  logic [47:0] r_p;        // P register
  logic [47:0] w_p_next;   // SIMD ALU result
  logic [3:0]  w_carry;    // per-lane carry-out (only consumed with flags on)

  // Input and OPMODE registers, then P update. Idle cycles leave P untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ab   <= '0;
      r_zacc <= 1'b0;
      r_ce_p <= 1'b0;
      r_p    <= '0;
    end else begin
      if (valid_i) begin
        r_ab   <= dat_i;
        r_zacc <= ~r_first;
      end
      r_ce_p <= valid_i;
      if (r_ce_p) begin
        r_p <= w_p_next;
      end
    end
  end

  // Independent lane adders: carries never propagate into the next lane
  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    logic [LW-1:0] w_z;
    assign w_z = r_zacc ? r_p[k*LW +: LW] : '0;
`ifdef SIMD_ACCUM_OVF_EN
    logic [LW:0] w_sum;
    assign w_sum                 = {1'b0, w_z} + {1'b0, r_ab[k*LW +: LW]};
    assign w_p_next[k*LW +: LW]  = w_sum[LW-1:0];
    assign w_carry[k]            = w_sum[LW];
`else
    assign w_p_next[k*LW +: LW]  = w_z + r_ab[k*LW +: LW];
    assign w_carry[k]            = 1'b0;
`endif
  end

  // Unused lane positions in TWO24 mode carry nothing
  for (genvar k = NLANE; k < 4; k++) begin : g_no_lane
    assign w_carry[k] = 1'b0;
  end

  assign dat_o = r_p;

`ifdef SIMD_ACCUM_OVF_EN
  // --------------------------------------------------------------------------
  // Sticky wrap flags: restart on the frame's Z=0 cycle (keeping that cycle's
  // carry), OR-accumulate afterwards, and snapshot onto ovf_o with valid_o.
  // --------------------------------------------------------------------------
  logic [3:0] r_sticky;
  logic [3:0] w_sticky_next;

  // Next sticky value for the sample entering P this cycle
  always_comb begin
    w_sticky_next = r_zacc ? (r_sticky | w_carry) : w_carry;
  end

  // Sticky accumulation and presentation aligned with the output strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sticky <= '0;
      ovf_o    <= '0;
    end else begin
      if (r_ce_p) begin
        r_sticky <= w_sticky_next;
      end
      if (r_eof_d1) begin
        ovf_o <= w_sticky_next;
      end
    end
  end
`else
  logic w_carry_unused;
  assign w_carry_unused = |w_carry;
  assign ovf_o          = 4'b0;
`endif

endmodule
`default_nettype wire
